press_ctrl: RTL and testbench
=============================

PRESS_CTRL -- requirements
Module: press_ctrl

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 100, giving the consecutive high samples of pb_de that make a long press (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the hold-counter width; LONG_CYCLES SHALL be at most 2^CNT_W-1.
REQ-003 The block SHALL have port clk_100  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port pb_de  input  1  debounced push-button level from the upstream debouncer, synchronous to clk_100.
REQ-006 The block SHALL have port press_pulse  output  1  one-cycle pulse for each press onset.
REQ-007 The block SHALL have port short_pulse  output  1  one-cycle pulse when a press shorter than LONG_CYCLES is released.
REQ-008 The block SHALL have port long_pulse  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-009 The block SHALL have port run  output  1  level, high while the mode is RUN (timer count enable).
REQ-010 The block SHALL have port clr  output  1  one-cycle timer-clear pulse.
REQ-011 The block SHALL have port mode  output  2  current mode: 00 STOP, 01 RUN, 10 PAUSE; 11 never driven.

Function
REQ-012 The block SHALL register pb_de into pb_d every cycle; a sample is "high" when pb_de=1 at a clock edge.
REQ-013 The button FSM SHALL have states IDLE, PRESSED and HELD.
REQ-014 In IDLE with pb_de=1 the FSM SHALL go to PRESSED, load hold_cnt=1 and assert press_pulse in the following cycle.
REQ-015 In PRESSED with pb_de=1 the FSM SHALL increment hold_cnt.
REQ-016 When hold_cnt reaches LONG_CYCLES the FSM SHALL go to HELD and assert long_pulse in the cycle after the LONG_CYCLES-th consecutive high sample.
REQ-017 In PRESSED with pb_de=0 the FSM SHALL go to IDLE and assert short_pulse in the following cycle.
REQ-018 In HELD, hold_cnt SHALL saturate and no further pulses SHALL issue; pb_de=0 SHALL return the FSM to IDLE with no short_pulse.
REQ-019 press_pulse, short_pulse, long_pulse and clr SHALL be registered, each high for exactly one cycle per event, and never high on consecutive cycles.
REQ-020 short_pulse and long_pulse SHALL be mutually exclusive for any single press.
REQ-021 The mode FSM SHALL update on the same edge that raises short_pulse or long_pulse, so run and mode show the new value in the pulse cycle.
REQ-022 On short_pulse the mode SHALL change STOP->RUN, RUN->PAUSE and PAUSE->RUN.
REQ-023 On long_pulse the mode SHALL change to STOP from any mode and clr SHALL assert in the same cycle as long_pulse.
REQ-024 run SHALL equal (mode==RUN) and be driven from a register.
REQ-025 A one-cycle pb_de high (release sampled on the next edge) SHALL count as a short press.
REQ-026 pb_de held high through reset release SHALL NOT produce press_pulse until pb_de has been sampled low at least once after reset.

Reset
REQ-027 While rst=1 the block SHALL hold button FSM=IDLE, hold_cnt=0, pb_d=1, mode=STOP and all outputs at 0.
REQ-028 rst asserted mid-press SHALL abort the press with no short_pulse or long_pulse after release.
REQ-029 No initial blocks SHALL be relied on; reset SHALL be the only source of defined state.

Structure
REQ-030 A shared package press_pkg SHALL hold the button-state and mode encodings (IDLE/PRESSED/HELD; STOP=2'b00, RUN=2'b01, PAUSE=2'b10).
REQ-031 The button FSM SHALL be a sub-module press_classify (pb_de in; press/short/long pulses out), with the mode FSM in press_ctrl.

Verification (LONG_CYCLES=4)
REQ-032 rst pulse, then pb_de=0 for 10 cycles -> all outputs 0, mode=00.
REQ-033 pb_de high 2 cycles then low -> press_pulse 1 cycle after first high; short_pulse 1 cycle after first low; mode 00->01, run=1.
REQ-034 From RUN, pb_de high 10 cycles -> long_pulse and clr together 1 cycle after 4th high sample, mode=00, run=0; no pulse on release.
REQ-035 Short presses ×3 from STOP -> mode 01, 10, 01; run toggles 1, 0, 1.
REQ-036 Press held 3 cycles, rst asserted, pb_de kept high then released -> no pulses, mode=00; next short press -> mode=01.
REQ-037 pb_de=1 across reset release -> no press_pulse until pb_de goes low then high again.

Source files
------------

// File: rtl/press_pkg.sv
// Shared encodings for the push-button classifier and the RUN/PAUSE/STOP mode machine.
package press_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PRESSED = 2'b01,
      HELD    = 2'b10
   } btn_state_t;

   typedef enum logic [MODE_W-1:0] {
      STOP  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } mode_t;

   // Short press toggles between RUN and PAUSE; from STOP it starts running.
   function automatic mode_t mode_after_short(input mode_t m);
      return (m == RUN) ? PAUSE : RUN;
   endfunction

endpackage

// File: rtl/press_classify.sv
// Classifies a debounced button level into press-onset, short-release and long-hold pulses.
module press_classify
   import press_pkg::*;
#(
   parameter int unsigned LONG_CYCLES = 100,
   parameter int unsigned CNT_W       = 8
) (
   input  logic clk_100,
   input  logic rst,
   input  logic pb_de,
   output logic press_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic short_c,
   output logic long_c
);

   localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);

   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             pb_d_q;
   logic             press_c;

   // Onset needs a low sample first, so a level held through reset is ignored.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_c    = 1'b0;
      short_c    = 1'b0;
      long_c     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pb_de && !pb_d_q) begin
               state_d    = PRESSED;
               hold_cnt_d = CNT_W'(1);
               press_c    = 1'b1;
            end
         end
         PRESSED: begin
            if (!pb_de) begin
               state_d    = IDLE;
               hold_cnt_d = '0;
               short_c    = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
               if (hold_cnt_q == LONG_M1) begin
                  state_d = HELD;
                  long_c  = 1'b1;
               end
            end
         end
         HELD: begin
            if (!pb_de) begin
               state_d    = IDLE;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         pb_d_q      <= 1'b1;
         press_pulse <= 1'b0;
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         pb_d_q      <= pb_de;
         press_pulse <= press_c;
         short_pulse <= short_c;
         long_pulse  <= long_c;
      end
   end

endmodule

// File: rtl/press_ctrl.sv
// Single-button timer control: short press starts/pauses, long press stops and clears.
module press_ctrl
   import press_pkg::*;
#(
   parameter int unsigned LONG_CYCLES = 100,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk_100,
   input  logic       rst,
   input  logic       pb_de,
   output logic       press_pulse,
   output logic       short_pulse,
   output logic       long_pulse,
   output logic       run,
   output logic       clr,
   output logic [1:0] mode
);

   logic  short_c, long_c;
   mode_t mode_q, mode_d;
   logic  run_q, run_d;
   logic  clr_q, clr_d;

   press_classify #(
      .LONG_CYCLES (LONG_CYCLES),
      .CNT_W       (CNT_W)
   ) u_classify (
      .clk_100     (clk_100),
      .rst         (rst),
      .pb_de       (pb_de),
      .press_pulse (press_pulse),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .short_c     (short_c),
      .long_c      (long_c)
   );

   // Mode follows the classifier's next-cycle pulses so it changes in the pulse cycle.
   always_comb begin
      mode_d = mode_q;
      clr_d  = 1'b0;
      if (long_c) begin
         mode_d = STOP;
         clr_d  = 1'b1;
      end else if (short_c) begin
         mode_d = mode_after_short(mode_q);
      end
      run_d = (mode_d == RUN);
   end

   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         mode_q <= STOP;
         run_q  <= 1'b0;
         clr_q  <= 1'b0;
      end else begin
         mode_q <= mode_d;
         run_q  <= run_d;
         clr_q  <= clr_d;
      end
   end

   assign mode = mode_q;
   assign run  = run_q;
   assign clr  = clr_q;

endmodule

// File: tb/tb_press_ctrl.sv
// Bench for press_ctrl: run-length button model plus directed button sequences.
module tb_press_ctrl;

   localparam int LONG = 4;

   logic       clk_100 = 1'b0;
   logic       rst;
   logic       pb_de;
   logic       press_pulse, short_pulse, long_pulse, run, clr;
   logic [1:0] mode;

   int n_vec = 0;
   int n_err = 0;

   press_ctrl #(.LONG_CYCLES(LONG), .CNT_W(8)) dut (
      .clk_100     (clk_100),
      .rst         (rst),
      .pb_de       (pb_de),
      .press_pulse (press_pulse),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .run         (run),
      .clr         (clr),
      .mode        (mode)
   );

   always #5 clk_100 = ~clk_100;

   // Model: count consecutive armed high samples; events fire on run-length milestones.
   int         m_highs, n_highs;
   logic       m_armed, n_armed;
   logic [1:0] m_mode, n_mode;
   logic       e_press, e_short, e_long, e_clr;
   logic       n_press, n_short, n_long;

   always_comb begin
      n_highs = m_highs;
      n_armed = m_armed;
      n_mode  = m_mode;
      n_press = 1'b0;
      n_short = 1'b0;
      n_long  = 1'b0;
      if (pb_de) begin
         if (m_armed && m_highs <= LONG) begin
            n_highs = m_highs + 1;
            if (n_highs == 1) n_press = 1'b1;
            if (n_highs == LONG) begin
               n_long = 1'b1;
               n_mode = 2'b00;
            end
         end
      end else begin
         if (m_highs > 0 && m_highs < LONG) begin
            n_short = 1'b1;
            n_mode  = (m_mode == 2'b01) ? 2'b10 : 2'b01;
         end
         n_highs = 0;
         n_armed = 1'b1;
      end
   end

   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         m_highs <= 0;
         m_armed <= 1'b0;
         m_mode  <= 2'b00;
         e_press <= 1'b0;
         e_short <= 1'b0;
         e_long  <= 1'b0;
         e_clr   <= 1'b0;
      end else begin
         m_highs <= n_highs;
         m_armed <= n_armed;
         m_mode  <= n_mode;
         e_press <= n_press;
         e_short <= n_short;
         e_long  <= n_long;
         e_clr   <= n_long;
      end
   end

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk_100) begin
      chk("model press_pulse", {1'b0, press_pulse}, {1'b0, e_press});
      chk("model short_pulse", {1'b0, short_pulse}, {1'b0, e_short});
      chk("model long_pulse",  {1'b0, long_pulse},  {1'b0, e_long});
      chk("model clr",         {1'b0, clr},         {1'b0, e_clr});
      chk("model mode",        mode,                m_mode);
      chk("model run",         {1'b0, run},         {1'b0, (m_mode == 2'b01)});
   end

   // Drive one sample; return at the following negedge with its outputs visible.
   task automatic tick(input logic v);
      pb_de = v;
      @(posedge clk_100);
      @(negedge clk_100);
   endtask

   task automatic pulse_reset;
      @(negedge clk_100);
      #2 rst = 1'b1;
      @(negedge clk_100);
      chk("rst mode", mode, 2'b00);
      chk("rst outs", {1'b0, press_pulse | short_pulse | long_pulse | run | clr}, 2'b00);
      @(negedge clk_100);
      #2 rst = 1'b0;
   endtask

   initial begin
      pb_de = 1'b0;
      rst   = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk_100);
      chk("reset mode", mode, 2'b00);
      chk("reset outs", {1'b0, press_pulse | short_pulse | long_pulse | run | clr}, 2'b00);
      #2 rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) tick(1'b0);
      chk("idle mode", mode, 2'b00);
      chk("idle run", {1'b0, run}, 2'b00);

      // Two-sample press: press then short, STOP->RUN
      tick(1'b1);
      chk("p1 press", {1'b0, press_pulse}, 2'b01);
      tick(1'b1);
      chk("p1 press once", {1'b0, press_pulse}, 2'b00);
      tick(1'b0);
      chk("p1 short", {1'b0, short_pulse}, 2'b01);
      chk("p1 mode", mode, 2'b01);
      chk("p1 run", {1'b0, run}, 2'b01);
      tick(1'b0);
      chk("p1 short once", {1'b0, short_pulse}, 2'b00);

      // Long hold from RUN
      for (int i = 1; i <= 10; i++) begin
         tick(1'b1);
         chk("hold long", {1'b0, long_pulse}, (i == LONG) ? 2'b01 : 2'b00);
         chk("hold clr", {1'b0, clr}, (i == LONG) ? 2'b01 : 2'b00);
         if (i == LONG) begin
            chk("hold mode", mode, 2'b00);
            chk("hold run", {1'b0, run}, 2'b00);
         end
      end
      tick(1'b0);
      chk("hold release short", {1'b0, short_pulse}, 2'b00);
      tick(1'b0);

      // Three one-sample presses: RUN, PAUSE, RUN
      for (int k = 0; k < 3; k++) begin
         tick(1'b1);
         tick(1'b0);
         chk("toggle short", {1'b0, short_pulse}, 2'b01);
         chk("toggle mode", mode, (k == 1) ? 2'b10 : 2'b01);
         chk("toggle run", {1'b0, run}, (k == 1) ? 2'b00 : 2'b01);
      end
      tick(1'b0);

      // Reset mid-press, button held through release of reset
      for (int i = 0; i < 3; i++) tick(1'b1);
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         chk("abort press", {1'b0, press_pulse}, 2'b00);
      end
      tick(1'b0);
      chk("abort short", {1'b0, short_pulse}, 2'b00);
      chk("abort mode", mode, 2'b00);
      tick(1'b1);
      chk("post abort press", {1'b0, press_pulse}, 2'b01);
      tick(1'b0);
      chk("post abort mode", mode, 2'b01);
      tick(1'b0);

      // Button high across reset release needs a low sample before the next press
      pb_de = 1'b1;
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         chk("armed press", {1'b0, press_pulse}, 2'b00);
         chk("armed long", {1'b0, long_pulse}, 2'b00);
      end
      tick(1'b0);
      chk("armed short", {1'b0, short_pulse}, 2'b00);
      tick(1'b1);
      chk("rearm press", {1'b0, press_pulse}, 2'b01);
      tick(1'b0);
      chk("rearm short", {1'b0, short_pulse}, 2'b01);
      chk("rearm mode", mode, 2'b01);
      repeat (3) tick(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
